// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared source encodings, tag type and default parameters
package mem_rd_pkg;
   localparam logic SRC_FETCH = 1'b0;
   localparam logic SRC_LOAD = 1'b1;
   localparam int LAT_DEF = 2;
   localparam int STARVE_DEF = 4;
   typedef struct packed {
      logic valid;
      logic src;
   } tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: LAT-deep shift register of read tags with per-source kill
module rd_tag_pipe
   import mem_rd_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic       clk,
   input  logic       clr_i,
   input  tag_t       tag_i,
   input  logic [1:0] kill_i,
   output tag_t       resp_o,
   output logic       any_o
);
   tag_t pipe_q [LAT];
   tag_t pipe_d [LAT];
   // killed view is used both for the live response and for shifting
   always_comb begin
      any_o = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i];
         pipe_d[i].valid = pipe_q[i].valid & ~kill_i[pipe_q[i].src];
         any_o = any_o | pipe_q[i].valid;
      end
      resp_o = pipe_d[LAT-1];
   end
   always_ff @(posedge clk) begin
      if (clr_i) begin
         pipe_q <= '{default: '0};
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_d[i-1];
      end
   end
endmodule

// File: rtl/mem_rd_arb.sv
// mem_rd_arb: fetch/load arbiter and response router for a pipelined memory read port
module mem_rd_arb
   import mem_rd_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int LAT = LAT_DEF,
   parameter int STARVE = STARVE_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   input  logic          f_flush,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          l_req,
   input  logic [AW-1:0] l_addr,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          idle
);
   logic [3:0]    starve_q, starve_d;
   logic [AW-1:0] last_q, last_d;
   logic          starved, busy;
   tag_t          tag, resp;
   always_comb begin
      starved = starve_q == 4'(STARVE);
      f_gnt = rst_n & f_req & ~f_flush & (~l_req | starved);
      l_gnt = rst_n & l_req & ~(f_req & ~f_flush & starved);
      mem_addr = !rst_n ? '0 : f_gnt ? f_addr : l_gnt ? l_addr : last_q;
      last_d = mem_addr;
      starve_d = (f_gnt | ~f_req) ? 4'd0 : (f_flush | starved) ? starve_q : starve_q + 4'd1;
      tag.valid = f_gnt | l_gnt;
      tag.src = l_gnt ? SRC_LOAD : SRC_FETCH;
      f_rvalid = rst_n & resp.valid & (resp.src == SRC_FETCH);
      l_rvalid = rst_n & resp.valid & (resp.src == SRC_LOAD);
      f_rdata = f_rvalid ? mem_data : '0;
      l_rdata = l_rvalid ? mem_data : '0;
      idle = ~rst_n | ~busy;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_q <= '0;
         last_q <= '0;
      end else begin
         starve_q <= starve_d;
         last_q <= last_d;
      end
   end
   rd_tag_pipe #(.LAT(LAT)) u_pipe (
      .clk    (clk),
      .clr_i  (~rst_n),
      .tag_i  (tag),
      .kill_i ({1'b0, f_flush}),
      .resp_o (resp),
      .any_o  (busy)
   );
endmodule

// File: tb/tb_mem_rd_arb.sv
// tb_mem_rd_arb: directed scenario checks for mem_rd_arb with LAT=2, STARVE=4
module tb_mem_rd_arb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req, f_gnt, f_flush, f_rvalid;
   logic [15:0] f_addr, f_rdata;
   logic        l_req, l_gnt, l_rvalid;
   logic [15:0] l_addr, l_rdata;
   logic [15:0] mem_addr, mem_data;
   logic        idle;
   logic [15:0] a1 = '0, a2 = '0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // memory model: data = address presented two cycles earlier, scrambled
   always @(posedge clk) begin
      a1 <= mem_addr;
      a2 <= a1;
   end
   assign mem_data = a2 ^ 16'hBEEF;

   mem_rd_arb dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_flush(f_flush),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt),
      .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .idle(idle)
   );

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      f_req = 0; l_req = 0; f_flush = 0; f_addr = '0; l_addr = '0;
   endtask

   task automatic test_reset;
      rst_n = 0; f_req = 1; l_req = 1; f_flush = 0; f_addr = 16'h11; l_addr = 16'h22;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({f_gnt, l_gnt, f_rvalid, l_rvalid} !== 4'b0 || idle !== 1'b1 || mem_addr !== 16'h0
             || f_rdata !== 16'h0 || l_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset c%0d: gnt=%b%b rv=%b%b idle=%b addr=%h rd=%h/%h, need all 0, idle 1",
                     c, f_gnt, l_gnt, f_rvalid, l_rvalid, idle, mem_addr, f_rdata, l_rdata);
         end
         next_cycle();
      end
      quiet();
      rst_n = 1;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_fetch_only;
      logic exp_rv;
      logic [15:0] exp_rd;
      for (int c = 0; c < 6; c++) begin
         f_req = c < 3; f_addr = 16'(c);
         exp_rv = c >= 2 && c <= 4;
         exp_rd = exp_rv ? 16'(c - 2) ^ 16'hBEEF : 16'h0;
         @(negedge clk);
         checks++;
         if (f_gnt !== (c < 3) || l_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_gnt c%0d: f_gnt=%b l_gnt=%b need %b 0", c, f_gnt, l_gnt, c < 3);
         end
         checks++;
         if (f_rvalid !== exp_rv || f_rdata !== exp_rd || l_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_resp c%0d: f_rvalid=%b f_rdata=%h l_rvalid=%b need %b %h 0",
                     c, f_rvalid, f_rdata, l_rvalid, exp_rv, exp_rd);
         end
         if (c >= 1 && c <= 4) begin
            checks++;
            if (idle !== 1'b0) begin
               errors++;
               $display("FAIL fetch_idle c%0d: idle=%b need 0", c, idle);
            end
         end
         next_cycle();
      end
      quiet();
   endtask

   task automatic test_contention;
      logic exp_fg, exp_lg, exp_fr, exp_lr;
      for (int c = 0; c < 9; c++) begin
         f_req = c < 6; f_addr = 16'h5; l_req = c < 6; l_addr = 16'h20;
         exp_fg = c == 4;
         exp_lg = c < 6 && c != 4;
         exp_fr = c == 6;
         exp_lr = (c >= 2 && c <= 5) || c == 7;
         @(negedge clk);
         checks++;
         if (f_gnt !== exp_fg || l_gnt !== exp_lg) begin
            errors++;
            $display("FAIL contend_gnt c%0d: f_gnt=%b l_gnt=%b need %b %b", c, f_gnt, l_gnt, exp_fg, exp_lg);
         end
         checks++;
         if (f_rvalid !== exp_fr || l_rvalid !== exp_lr
             || f_rdata !== (exp_fr ? 16'h5 ^ 16'hBEEF : 16'h0)
             || l_rdata !== (exp_lr ? 16'h20 ^ 16'hBEEF : 16'h0)) begin
            errors++;
            $display("FAIL contend_resp c%0d: f_rv=%b f_rd=%h l_rv=%b l_rd=%h need f_rv=%b l_rv=%b",
                     c, f_rvalid, f_rdata, l_rvalid, l_rdata, exp_fr, exp_lr);
         end
         next_cycle();
      end
      quiet();
   endtask

   task automatic test_flush;
      logic exp_fg, exp_fr;
      for (int c = 0; c < 7; c++) begin
         f_req = c < 4;
         f_addr = c < 2 ? 16'(16'h40 + c) : 16'h42;
         f_flush = c == 2;
         exp_fg = c == 0 || c == 1 || c == 3;
         exp_fr = c == 5;
         @(negedge clk);
         checks++;
         if (f_gnt !== exp_fg) begin
            errors++;
            $display("FAIL flush_gnt c%0d: f_gnt=%b need %b", c, f_gnt, exp_fg);
         end
         checks++;
         if (f_rvalid !== exp_fr || f_rdata !== (exp_fr ? 16'h42 ^ 16'hBEEF : 16'h0)) begin
            errors++;
            $display("FAIL flush_resp c%0d: f_rvalid=%b f_rdata=%h need %b", c, f_rvalid, f_rdata, exp_fr);
         end
         next_cycle();
      end
      quiet();
   endtask

   task automatic test_flush_load;
      logic exp_lr;
      for (int c = 0; c < 5; c++) begin
         l_req = c == 0; l_addr = 16'h50;
         f_req = c == 1; f_addr = 16'h60; f_flush = c == 1;
         exp_lr = c == 2;
         @(negedge clk);
         checks++;
         if (f_gnt !== 1'b0 || l_gnt !== (c == 0)) begin
            errors++;
            $display("FAIL flushld_gnt c%0d: f_gnt=%b l_gnt=%b need 0 %b", c, f_gnt, l_gnt, c == 0);
         end
         checks++;
         if (f_rvalid !== 1'b0 || l_rvalid !== exp_lr || l_rdata !== (exp_lr ? 16'h50 ^ 16'hBEEF : 16'h0)) begin
            errors++;
            $display("FAIL flushld_resp c%0d: f_rv=%b l_rv=%b l_rd=%h need 0 %b", c, f_rvalid, l_rvalid, l_rdata, exp_lr);
         end
         next_cycle();
      end
      quiet();
   endtask

   task automatic test_reset_midflight;
      for (int c = 0; c < 6; c++) begin
         l_req = c <= 2; l_addr = 16'(16'h70 + c);
         rst_n = c != 2;
         @(negedge clk);
         if (c < 2) begin
            checks++;
            if (l_gnt !== 1'b1) begin
               errors++;
               $display("FAIL rstmid_gnt c%0d: l_gnt=%b need 1", c, l_gnt);
            end
         end else begin
            checks++;
            if (l_gnt !== 1'b0 || l_rvalid !== 1'b0 || l_rdata !== 16'h0 || idle !== 1'b1 || mem_addr !== 16'h0) begin
               errors++;
               $display("FAIL rstmid c%0d: l_gnt=%b l_rv=%b l_rd=%h idle=%b addr=%h need 0 0 0 1 0",
                        c, l_gnt, l_rvalid, l_rdata, idle, mem_addr);
            end
         end
         next_cycle();
      end
      rst_n = 1;
      quiet();
   endtask

   task automatic test_idle_hold;
      for (int c = 0; c < 4; c++) begin
         l_req = c == 0; l_addr = c == 0 ? 16'h33 : 16'h99;
         @(negedge clk);
         checks++;
         if (mem_addr !== 16'h33) begin
            errors++;
            $display("FAIL hold_addr c%0d: mem_addr=%h need 0033", c, mem_addr);
         end
         if (c > 0) begin
            checks++;
            if (idle !== (c == 3) || l_rvalid !== (c == 2)) begin
               errors++;
               $display("FAIL hold_idle c%0d: idle=%b l_rvalid=%b need %b %b", c, idle, l_rvalid, c == 3, c == 2);
            end
         end
         next_cycle();
      end
      quiet();
   endtask

   initial begin
      quiet();
      rst_n = 0;
      #1;
      test_reset();
      test_fetch_only();
      test_contention();
      test_flush();
      test_flush_load();
      test_reset_midflight();
      test_idle_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
